// File: rtl/detector_pulse_gen_pkg.sv
// Shared settings for the detector pulse generator and the trapezoidal shaping filter:
// sample width, state encoding, noise LFSR constants and a signed saturation helper.
package detector_pulse_gen_pkg;

  localparam int SIZE_FILTER_DATA = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_DRAIN = 2'd2
  } pulse_state_e;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form.
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Clamp a sign-extended value into the signed range of a width-bit sample.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] value,
                                                  input int                 width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/detector_pulse_gen_if.sv
// Control and sample bus between a pulse-generator client (master) and the generator (slave).
interface detector_pulse_gen_if #(
  parameter int SIZE_FILTER_DATA = detector_pulse_gen_pkg::SIZE_FILTER_DATA,
  parameter int SIZE_PERIOD      = 16,
  parameter int SIZE_COUNT       = 8
);

  logic                               start;
  logic                               stop;
  logic signed [SIZE_FILTER_DATA-1:0] amplitude;
  logic        [SIZE_PERIOD-1:0]      period;
  logic        [SIZE_COUNT-1:0]       pulse_count;
  logic        [3:0]                  decay_shift;
  logic signed [SIZE_FILTER_DATA-1:0] output_data;
  logic                               pulse_strobe;
  logic                               busy;

  modport master (
    output start, stop, amplitude, period, pulse_count, decay_shift,
    input  output_data, pulse_strobe, busy
  );

  modport slave (
    input  start, stop, amplitude, period, pulse_count, decay_shift,
    output output_data, pulse_strobe, busy
  );

endinterface

// File: rtl/pulse_gen_lfsr.sv
// 16-bit Galois LFSR noise source for the pulse generator; exposes its low NOISE_BITS+1 bits
// as a signed noise sample. Built only when PULSE_GEN_NOISE_EN is defined.
module pulse_gen_lfsr
  import detector_pulse_gen_pkg::*;
#(
  parameter int NOISE_BITS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic signed [NOISE_BITS:0] noise_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign noise_o = lfsr_q[NOISE_BITS:0];

endmodule

// File: rtl/detector_pulse_gen.sv
// Synthetic exponentially-decaying detector pulse source feeding the shaping filter input.
// Optional additive LFSR noise on the output is enabled by defining PULSE_GEN_NOISE_EN.
module detector_pulse_gen
  import detector_pulse_gen_pkg::*;
#(
  parameter int SIZE_FILTER_DATA = detector_pulse_gen_pkg::SIZE_FILTER_DATA,
  parameter int SIZE_PERIOD      = 16,
  parameter int SIZE_COUNT       = 8,
  parameter int NOISE_BITS       = 3
) (
  input  logic                clk,
  input  logic                reset,
  detector_pulse_gen_if.slave bus
);

  localparam int SUM_W = SIZE_FILTER_DATA + 2;

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] PULSE = ST_PULSE;
  localparam logic [1:0] DRAIN = ST_DRAIN;

  if (SUM_W > 32 || NOISE_BITS < 0 || NOISE_BITS + 1 > SIZE_FILTER_DATA) begin : g_param_check
    $error("detector_pulse_gen: unsupported SIZE_FILTER_DATA/NOISE_BITS combination");
  end

  logic [1:0]                        state_q,  state_d;
  logic signed [SIZE_FILTER_DATA-1:0] acc_q,   acc_d;
  logic signed [SIZE_FILTER_DATA-1:0] amp_q,   amp_d;
  logic        [SIZE_PERIOD-1:0]      period_q, period_d;
  logic        [3:0]                  shift_q, shift_d;
  logic        [SIZE_PERIOD-1:0]      cnt_q,   cnt_d;
  logic        [SIZE_COUNT-1:0]       rem_q,   rem_d;
  logic                               free_q,  free_d;
  logic                               strobe_q, strobe_d;

  logic signed [SIZE_FILTER_DATA-1:0] dec_raw;
  logic signed [SIZE_FILTER_DATA-1:0] dec;
  logic signed [SIZE_FILTER_DATA-1:0] acc_decay;
  logic signed [SUM_W-1:0]            pulse_sum;
  logic signed [SIZE_FILTER_DATA-1:0] pulse_acc;
  logic        [SIZE_PERIOD-1:0]      period_in;
  logic        [3:0]                  shift_in;

  // Decay term and the saturated value a pulse cycle would produce.
  always_comb begin
    dec_raw = acc_q >>> shift_q;
    if (dec_raw == '0 && acc_q != '0) begin
      dec = acc_q[SIZE_FILTER_DATA-1] ? '1 : SIZE_FILTER_DATA'(1);
    end else begin
      dec = dec_raw;
    end
    acc_decay = acc_q - dec;
    pulse_sum = SUM_W'(acc_decay) + SUM_W'(amp_q);
    pulse_acc = SIZE_FILTER_DATA'(saturate(32'(pulse_sum), SIZE_FILTER_DATA));

    period_in = (bus.period < SIZE_PERIOD'(2)) ? SIZE_PERIOD'(2) : bus.period;
    shift_in  = (bus.decay_shift == 4'd0) ? 4'd1 : bus.decay_shift;
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    acc_d    = acc_q;
    amp_d    = amp_q;
    period_d = period_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    free_d   = free_q;
    strobe_d = 1'b0;

    case (state_q)
      IDLE: begin
        acc_d = '0;
        if (bus.start && !bus.stop) begin
          state_d  = PULSE;
          amp_d    = bus.amplitude;
          period_d = period_in;
          shift_d  = shift_in;
          free_d   = (bus.pulse_count == '0);
          rem_d    = (bus.pulse_count == '0) ? '0 : bus.pulse_count - SIZE_COUNT'(1);
          cnt_d    = period_in - SIZE_PERIOD'(1);
          acc_d    = bus.amplitude;
          strobe_d = 1'b1;
        end
      end

      PULSE: begin
        // A stop on the period-expiry cycle wins over the pending pulse.
        if (bus.stop || (!free_q && rem_q == '0)) begin
          state_d = DRAIN;
          acc_d   = acc_decay;
        end else if (cnt_q == '0) begin
          acc_d    = pulse_acc;
          strobe_d = 1'b1;
          cnt_d    = period_q - SIZE_PERIOD'(1);
          if (!free_q) rem_d = rem_q - SIZE_COUNT'(1);
        end else begin
          acc_d = acc_decay;
          cnt_d = cnt_q - SIZE_PERIOD'(1);
        end
      end

      DRAIN: begin
        acc_d = acc_decay;
        if (acc_decay == '0) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        acc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      amp_q    <= '0;
      period_q <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      free_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      amp_q    <= amp_d;
      period_q <= period_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      free_q   <= free_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.pulse_strobe = strobe_q;
  assign bus.busy         = (state_q != IDLE);

`ifdef PULSE_GEN_NOISE_EN
  logic signed [NOISE_BITS:0] noise;

  pulse_gen_lfsr #(
    .NOISE_BITS (NOISE_BITS)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .noise_o (noise)
  );

  // Noise only shapes the output; the accumulator and state machine never see it.
  assign bus.output_data = SIZE_FILTER_DATA'(saturate(32'(acc_q) + 32'(noise), SIZE_FILTER_DATA));
`else
  assign bus.output_data = acc_q;
`endif

endmodule

// File: tb/tb_detector_pulse_gen.sv
// Self-checking bench for detector_pulse_gen: cycle scoreboard against a behavioural model
// plus scenario tasks checking the hand-derived values of each feature.
module tb_detector_pulse_gen;

  localparam int N  = 16;
  localparam int P  = 16;
  localparam int C  = 8;
  localparam int NB = 3;

  typedef struct {
    int out;
    bit strobe;
    bit busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  detector_pulse_gen_if #(.SIZE_FILTER_DATA(N), .SIZE_PERIOD(P), .SIZE_COUNT(C)) bus ();

  detector_pulse_gen #(
    .SIZE_FILTER_DATA (N),
    .SIZE_PERIOD      (P),
    .SIZE_COUNT       (C),
    .NOISE_BITS       (NB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  exp_t sb_q[$];

  // Behavioural model state (0 idle, 1 pulsing, 2 draining).
  int          m_state  = 0;
  int          m_acc    = 0;
  int          m_amp    = 0;
  int          m_per    = 2;
  int          m_shift  = 1;
  int          m_count  = 0;
  int          m_issued = 0;
  int          m_since  = 0;
  bit          m_strobe = 1'b0;
  logic [15:0] m_lfsr   = 16'hACE1;

  function automatic int decay_of(int acc, int sh);
    int d;
    d = acc >>> sh;
    if (d == 0 && acc != 0) d = (acc > 0) ? 1 : -1;
    return d;
  endfunction

  function automatic int sat_n(int v);
    int hi;
    hi = (1 <<< (N - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  function automatic int noise_of(logic [15:0] l);
    int n;
    n = int'(l[NB:0]);
    if (n >= (1 << NB)) n = n - (1 << (NB + 1));
    return n;
  endfunction

  function automatic int out_now();
    return int'($signed(bus.output_data));
  endfunction

  // Advance the model by one edge using the currently driven inputs; queue the expectation.
  task automatic model_next();
    exp_t e;
    int   d;
    if (reset) begin
      m_state  = 0;
      m_acc    = 0;
      m_strobe = 1'b0;
      m_issued = 0;
      m_since  = 0;
      m_lfsr   = 16'hACE1;
    end else begin
      d        = decay_of(m_acc, m_shift);
      m_strobe = 1'b0;
      m_lfsr   = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      case (m_state)
        0: if (bus.start && !bus.stop) begin
          m_amp    = int'($signed(bus.amplitude));
          m_per    = (int'(bus.period) < 2) ? 2 : int'(bus.period);
          m_shift  = (bus.decay_shift == 4'd0) ? 1 : int'(bus.decay_shift);
          m_count  = int'(bus.pulse_count);
          m_acc    = m_amp;
          m_strobe = 1'b1;
          m_issued = 1;
          m_since  = 0;
          m_state  = 1;
        end
        1: begin
          if (bus.stop || (m_count != 0 && m_issued == m_count)) begin
            m_acc   = m_acc - d;
            m_state = 2;
          end else if (m_since + 1 >= m_per) begin
            m_acc    = sat_n(m_acc - d + m_amp);
            m_strobe = 1'b1;
            m_issued = m_issued + 1;
            m_since  = 0;
          end else begin
            m_acc   = m_acc - d;
            m_since = m_since + 1;
          end
        end
        default: begin
          m_acc = m_acc - d;
          if (m_acc == 0) m_state = 0;
        end
      endcase
    end
`ifdef PULSE_GEN_NOISE_EN
    e.out = sat_n(m_acc + noise_of(m_lfsr));
`else
    e.out = m_acc;
`endif
    e.strobe = m_strobe;
    e.busy   = (m_state != 0);
    sb_q.push_back(e);
  endtask

  // One clock: queue the model's expectation, let the DUT take the edge, pop and compare.
  task automatic tick();
    exp_t e;
    model_next();
    @(posedge clk);
    #1;
    cyc++;
    e = sb_q.pop_front();
    vectors++;
    if (bus.output_data !== N'(e.out)) begin
      miscompares++;
      $display("FAIL sb_output cycle %0d: got %0d expected %0d", cyc, out_now(), e.out);
    end
    vectors++;
    if (bus.pulse_strobe !== e.strobe) begin
      miscompares++;
      $display("FAIL sb_strobe cycle %0d: got %b expected %b", cyc, bus.pulse_strobe, e.strobe);
    end
    vectors++;
    if (bus.busy !== e.busy) begin
      miscompares++;
      $display("FAIL sb_busy cycle %0d: got %b expected %b", cyc, bus.busy, e.busy);
    end
  endtask

  task automatic arm(int amp, int per, int cnt, int sh);
    bus.amplitude   = N'(amp);
    bus.period      = P'(per);
    bus.pulse_count = C'(cnt);
    bus.decay_shift = 4'(sh);
    bus.start       = 1'b1;
    tick();
    bus.start       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    vectors++;
    if (bus.output_data !== '0) begin
      miscompares++;
      $display("FAIL reset_output: got %0d expected 0", out_now());
    end
    vectors++;
    if (bus.pulse_strobe !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got strobe=%b busy=%b expected 0 0", bus.pulse_strobe, bus.busy);
    end
    tick();
  endtask

`ifndef PULSE_GEN_NOISE_EN
  task automatic test_single_pulse();
    int seq[3] = '{1000, 938, 880};
    int strobes = 0;
    int n = 0;
    arm(1000, 100, 1, 4);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      if (bus.pulse_strobe === 1'b1) strobes++;
      vectors++;
      if (out_now() !== seq[i]) begin
        miscompares++;
        $display("FAIL single_seq[%0d]: got %0d expected %0d", i, out_now(), seq[i]);
      end
    end
    while (bus.busy === 1'b1 && n < 400) begin
      tick();
      if (bus.pulse_strobe === 1'b1) strobes++;
      n++;
    end
    vectors++;
    if (n >= 400) begin
      miscompares++;
      $display("FAIL single_timeout: got busy after %0d cycles expected idle", n);
    end
    vectors++;
    if (strobes !== 1) begin
      miscompares++;
      $display("FAIL single_strobes: got %0d expected 1", strobes);
    end
    vectors++;
    if (out_now() !== 0) begin
      miscompares++;
      $display("FAIL single_busy_fall: got output %0d when busy fell expected 0", out_now());
    end
  endtask

  task automatic test_pileup();
    int exp_at[3] = '{1, 11, 21};
    int seen[$];
    int prev;
    int want;
    int n = 0;
    arm(1000, 10, 3, 4);
    if (bus.pulse_strobe === 1'b1) seen.push_back(1);
    for (int k = 2; k <= 40; k++) begin
      prev = out_now();
      tick();
      if (bus.pulse_strobe === 1'b1) begin
        seen.push_back(k);
        if (k == 11) begin
          want = prev - decay_of(prev, 4) + 1000;
          vectors++;
          if (out_now() !== want) begin
            miscompares++;
            $display("FAIL pileup_sum: got %0d expected %0d", out_now(), want);
          end
        end
      end
    end
    vectors++;
    if (seen.size() !== 3) begin
      miscompares++;
      $display("FAIL pileup_count: got %0d strobes expected 3", seen.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (seen[i] !== exp_at[i]) begin
          miscompares++;
          $display("FAIL pileup_when[%0d]: got cycle %0d expected %0d", i, seen[i], exp_at[i]);
        end
      end
    end
    while (bus.busy === 1'b1 && n < 400) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= 400 || out_now() !== 0) begin
      miscompares++;
      $display("FAIL pileup_drain: got output %0d after %0d cycles expected 0", out_now(), n);
    end
  endtask

  task automatic test_small_drain();
    int amps[2] = '{5, -5};
    int want;
    for (int a = 0; a < 2; a++) begin
      arm(amps[a], 100, 1, 4);
      for (int i = 0; i < 6; i++) begin
        if (i > 0) tick();
        want = (amps[a] > 0) ? 5 - i : -5 + i;
        vectors++;
        if (out_now() !== want) begin
          miscompares++;
          $display("FAIL small_drain amp %0d step %0d: got %0d expected %0d", amps[a], i, out_now(), want);
        end
      end
      vectors++;
      if (bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL small_drain_busy amp %0d: got %b expected 0", amps[a], bus.busy);
      end
      tick();
    end
  endtask

  task automatic test_collision();
    int strobes = 0;
    arm(1000, 10, 3, 4);
    for (int k = 2; k <= 10; k++) begin
      if (k == 5) begin
        bus.start     = 1'b1;
        bus.amplitude = N'(-7);
      end
      tick();
      if (k == 5) begin
        bus.start = 1'b0;
        vectors++;
        if (bus.pulse_strobe !== 1'b0) begin
          miscompares++;
          $display("FAIL start_while_busy: got strobe %b expected 0", bus.pulse_strobe);
        end
      end
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    vectors++;
    if (bus.pulse_strobe !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL stop_on_expiry: got strobe=%b busy=%b expected 0 1", bus.pulse_strobe, bus.busy);
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.pulse_strobe === 1'b1) strobes++;
    end
    vectors++;
    if (strobes !== 0) begin
      miscompares++;
      $display("FAIL stop_no_more_pulses: got %0d strobes expected 0", strobes);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (bus.output_data !== '0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_decay: got output=%0d busy=%b expected 0 0", out_now(), bus.busy);
    end
    tick();
  endtask

  task automatic test_saturation();
    int lo = 100000;
    int hi = -100000;
    int strobes = 0;
    int n = 0;
    arm(30000, 2, 0, 15);
    for (int k = 2; k <= 24; k++) begin
      tick();
      if (k >= 3) begin
        if (out_now() < lo) lo = out_now();
        if (out_now() > hi) hi = out_now();
      end
    end
    vectors++;
    if (hi !== 32767) begin
      miscompares++;
      $display("FAIL sat_peak: got %0d expected 32767", hi);
    end
    vectors++;
    if (lo < 32766) begin
      miscompares++;
      $display("FAIL sat_wrap: got minimum %0d expected at least 32766", lo);
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    if (bus.pulse_strobe === 1'b1) strobes++;
    while (bus.busy === 1'b1 && n < 40000) begin
      tick();
      if (bus.pulse_strobe === 1'b1) strobes++;
      n++;
    end
    vectors++;
    if (strobes !== 0) begin
      miscompares++;
      $display("FAIL sat_stop_strobes: got %0d expected 0", strobes);
    end
    vectors++;
    if (n >= 40000 || out_now() !== 0) begin
      miscompares++;
      $display("FAIL sat_drain: got output %0d after %0d cycles expected 0", out_now(), n);
    end
  endtask
`else
  task automatic test_noise();
    int bad = 0;
    int lim;
    lim = 1 << NB;
    arm(0, 100, 1, 4);
    for (int k = 0; k < 300; k++) begin
      if (out_now() > lim || out_now() < -lim) bad++;
      tick();
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL noise_bound: got %0d samples outside +-%0d expected 0", bad, lim);
    end
  endtask
`endif

  initial begin
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.amplitude   = '0;
    bus.period      = '0;
    bus.pulse_count = '0;
    bus.decay_shift = '0;
    test_reset();
`ifdef PULSE_GEN_NOISE_EN
    test_noise();
`else
    test_single_pulse();
    test_pileup();
    test_small_drain();
    test_collision();
    test_saturation();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no completion by cycle %0d expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
